// File: rtl/bit_serial_adder_if.sv
// Operand/result handshake bundle for bit_serial_adder; the Ovf wire exists only
// when BSA_OVF_EN is defined.
interface bit_serial_adder_if #(
    parameter int WIDTH = 8
);
    // Valid/ready: a transfer happens on a rising edge where both valid and ready
    // are high; the producer holds its payload steady until then, and ready may
    // depend combinationally on state but never on the payload.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
`ifdef BSA_OVF_EN
    logic             Ovf;
`endif

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, Sum, Cout
`ifdef BSA_OVF_EN
        , input Ovf
`endif
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, Sum, Cout
`ifdef BSA_OVF_EN
        , output Ovf
`endif
    );
endinterface

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-add per clock from two half-adder stages and a
// carry flop. Define BSA_OVF_EN to add the signed-overflow output Ovf.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    bit_serial_adder_if.slave     bus,
    output logic                  busy,
    output logic [1:0]            dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             ha1_s;
    logic             ha1_c;
    logic             s_bit;
    logic             ha2_c;
    logic             carry_n;

    // First half adder combines the operand bits, second folds in the carry.
    always_comb begin
        ha1_s   = a_sh[0] ^ b_sh[0];
        ha1_c   = a_sh[0] & b_sh[0];
        s_bit   = ha1_s ^ carry;
        ha2_c   = ha1_s & carry;
        carry_n = ha1_c | ha2_c;
    end

    assign bus.in_ready = (state == IDLE) && !reset;
    assign dbg_state    = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            a_sh          <= '0;
            b_sh          <= '0;
            carry         <= 1'b0;
            cnt           <= '0;
            bus.Sum       <= '0;
            bus.Cout      <= 1'b0;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
`ifdef BSA_OVF_EN
            bus.Ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh     <= bus.A;
                        b_sh     <= bus.B;
                        carry    <= bus.Cin;
                        cnt      <= '0;
                        bus.Sum  <= '0;
                        bus.Cout <= 1'b0;
                        busy     <= 1'b1;
`ifdef BSA_OVF_EN
                        bus.Ovf  <= 1'b0;
`endif
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bus.Sum <= {s_bit, bus.Sum[WIDTH-1:1]};
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry   <= carry_n;
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.Cout      <= carry_n;
                        bus.out_valid <= 1'b1;
                        busy          <= 1'b0;
`ifdef BSA_OVF_EN
                        // carry still holds the carry into the MSB on this edge
                        bus.Ovf       <= carry ^ carry_n;
`endif
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
